alu_flag_seq: RTL

Multi-cycle, slice-serial adder/subtractor that produces the 32-bit result and the Z/V/N flags consumed by the ALU comparison stage. It is the producing end of the flag interface: each operation computes A+B or A−B over several clock cycles, then presents S, Z, V and N under a valid/ready handshake. It sits between operand issue and the compare/result mux, and it is used where the single-cycle 32-bit adder would break timing.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_flag_seq_if.sv | 33 +++
 rtl/alu_slice_add.sv | 28 ++
 rtl/alu_flag_seq.sv | 121 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types, slice constants and flag helper for alu_flag_seq
//
// Purpose: FSM state encoding, slice width and slice count for the slice-serial
//          adder, plus the flag-selection helper used on the last slice.
// Ports:   none (package).
// Config:  ALU_FLAG_SEQ_WIDE_SLICE_EN selects 16-bit slices; otherwise 8-bit slices.

package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

`ifdef ALU_FLAG_SEQ_WIDE_SLICE_EN
    localparam int SW = 16;
`else
    localparam int SW = 8;
`endif

    localparam int ALU_WIDTH = 32;
    localparam int NSLICE    = ALU_WIDTH / SW;

    function automatic int slice_count(input int width);
        return width / SW;
    endfunction

    // Returns {V, N} from the last slice's carries and result MSB.
    function automatic logic [1:0] flag_vn(
        input logic sign,
        input logic sub,
        input logic cout,
        input logic cmsb,
        input logic msb
    );
        logic [1:0] vn;
        if (sign) begin
            vn = {cmsb ^ cout, msb};
        end else if (sub) begin
            // With B inverted and carry-in 1, a missing carry-out means a borrow.
            vn = {1'b0, ~cout};
        end else begin
            vn = {cout, 1'b0};
        end
        return vn;
    endfunction

endpackage

// File: rtl/alu_flag_seq_if.sv
// rtl/alu_flag_seq_if.sv - operand/result handshake bundle for alu_flag_seq
//
// Purpose: groups the operand handshake (in_valid/in_ready, A, B, Sub, Sign) and
//          the result handshake (out_valid/out_ready, S, Z, V, N).
// Modports: slave  - the adder (consumes operands, produces results)
//           master - the operand issuer / result consumer

interface alu_flag_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Sub;
    logic             Sign;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Z;
    logic             V;
    logic             N;

    modport slave (
        input  in_valid, A, B, Sub, Sign, out_ready,
        output in_ready, out_valid, S, Z, V, N
    );

    modport master (
        output in_valid, A, B, Sub, Sign, out_ready,
        input  in_ready, out_valid, S, Z, V, N
    );
endinterface

// File: rtl/alu_slice_add.sv
// rtl/alu_slice_add.sv - combinational SW-bit adder slice
//
// Purpose: one slice of the serial adder; exposes the carry into the slice MSB
//          so signed overflow can be formed on the most significant slice.
// Ports:   a, b  - slice operands (b already inverted for subtraction)
//          cin   - carry in
//          sum   - slice sum
//          cout  - carry out of the slice MSB
//          cmsb  - carry into the slice MSB

module alu_slice_add #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          cmsb
);
    logic [SW-1:0] low;

    // Add the lower SW-1 bits in an SW-bit result so the top bit is the MSB carry-in.
    assign low  = {1'b0, a[SW-2:0]} + {1'b0, b[SW-2:0]} + SW'(cin);
    assign cmsb = low[SW-1];
    assign sum  = {a[SW-1] ^ b[SW-1] ^ cmsb, low[SW-2:0]};
    assign cout = (a[SW-1] & b[SW-1]) | (a[SW-1] & cmsb) | (b[SW-1] & cmsb);
endmodule

// File: rtl/alu_flag_seq.sv
// rtl/alu_flag_seq.sv - slice-serial add/subtract with Z/V/N flags and valid/ready handshake
//
// Purpose: computes A+B or A-B one SW-bit slice per cycle (LSB first), then holds
//          S/Z/V/N under out_valid until out_ready. Accepts operands only in IDLE.
// Ports:   clk   - clock, rising edge
//          reset - synchronous, active-high
//          bus   - alu_flag_seq_if.slave (in_valid/in_ready, A, B, Sub, Sign,
//                  out_valid/out_ready, S, Z, V, N)
// Config:  ALU_FLAG_SEQ_WIDE_SLICE_EN (via alu_pkg) selects 16-bit slices, else 8-bit.

module alu_flag_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    alu_flag_seq_if.slave   bus
);
    localparam int NSL = slice_count(WIDTH);
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] RUN  = 2'(ST_RUN);
    localparam logic [1:0] DONE = 2'(ST_DONE);

    logic [1:0]       state, state_nx;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             sub_q, sign_q;
    logic             nz_q;
    logic             z_q, v_q, n_q;
    logic             in_ready_q, out_valid_q;

    logic [SW-1:0]    sl_sum;
    logic             sl_cout, sl_cmsb;
    logic             last, accept, handoff;
    logic [1:0]       vn;

    // Operands are shifted right each RUN cycle, so the active slice is always the bottom SW bits.
    alu_slice_add #(.SW(SW)) u_slice (
        .a    (a_q[SW-1:0]),
        .b    (b_q[SW-1:0]),
        .cin  (carry),
        .sum  (sl_sum),
        .cout (sl_cout),
        .cmsb (sl_cmsb)
    );

    assign last    = (cnt == CW'(NSL - 1));
    assign accept  = bus.in_valid && in_ready_q;
    assign handoff = out_valid_q && bus.out_ready;
    assign vn      = flag_vn(sign_q, sub_q, sl_cout, sl_cmsb, sl_sum[SW-1]);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)  state_nx = RUN;
            RUN:     if (last)    state_nx = DONE;
            DONE:    if (handoff) state_nx = IDLE;
            default:              state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            carry       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            sub_q       <= 1'b0;
            sign_q      <= 1'b0;
            nz_q        <= 1'b0;
            z_q         <= 1'b0;
            v_q         <= 1'b0;
            n_q         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nx;
            // Handshake outputs are registered decodes of the next state.
            in_ready_q  <= (state_nx == IDLE);
            out_valid_q <= (state_nx == DONE);

            if (state == IDLE && accept) begin
                a_q    <= bus.A;
                b_q    <= bus.Sub ? ~bus.B : bus.B;
                sub_q  <= bus.Sub;
                sign_q <= bus.Sign;
                carry  <= bus.Sub;
                cnt    <= '0;
                nz_q   <= 1'b0;
            end

            if (state == RUN) begin
                a_q   <= a_q >> SW;
                b_q   <= b_q >> SW;
                // Slices enter at the top and shift down; after NSL cycles S is in place.
                s_q   <= {sl_sum, s_q[WIDTH-1:SW]};
                carry <= sl_cout;
                nz_q  <= nz_q | (|sl_sum);
                cnt   <= last ? '0 : cnt + CW'(1);
                if (last) begin
                    z_q <= ~(nz_q | (|sl_sum));
                    v_q <= vn[1];
                    n_q <= vn[0];
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.S         = s_q;
    assign bus.Z         = z_q;
    assign bus.V         = v_q;
    assign bus.N         = n_q;
endmodule
